// File: rtl/seq_array_mult.sv
// Iterative shift-add multiplier: one operand pair per valid/ready transaction, WIDTH CALC cycles each.
// Define SEQ_ARRAY_MULT_SIGNED_EN for two's-complement operands (sign-extended a, subtracted top partial product).
module seq_array_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   a_reg;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [PW-1:0]   partial;
    logic [PW-1:0]   prod_q;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]   count;
    logic            last;

    assign last      = (count == CW'(WIDTH - 1));
    assign partial   = a_reg << count;
    assign prod      = prod_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        acc_next = acc;
        if (b_reg[count]) begin
`ifdef SEQ_ARRAY_MULT_SIGNED_EN
            // The multiplier's sign bit carries weight -2^(WIDTH-1).
            acc_next = last ? (acc - partial) : (acc + partial);
`else
            acc_next = acc + partial;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            count  <= '0;
            prod_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef SEQ_ARRAY_MULT_SIGNED_EN
                        a_reg <= {{WIDTH{a[WIDTH-1]}}, a};
`else
                        a_reg <= {{WIDTH{1'b0}}, a};
`endif
                        b_reg <= b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (last) prod_q <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_mult.sv
// Self-checking bench for seq_array_mult: WIDTH=4 and WIDTH=8 instances against an arithmetic product model.
// Honours SEQ_ARRAY_MULT_SIGNED_EN so the same bench covers the signed build.
module tb_seq_array_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, busy4;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] prod4;
    logic [1:0] dbg4;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] prod8;
    logic [1:0]  dbg8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    bit hold_valid = 1'b0;
    logic [63:0] exp_q[$];

    seq_array_mult #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .prod(prod4), .busy(busy4), .dbg_state(dbg4)
    );

    seq_array_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .prod(prod8), .busy(busy8), .dbg_state(dbg8)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer product of the operands, truncated to 2*w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, p;
        sa = longint'(av);
        sb = longint'(bv);
`ifdef SEQ_ARRAY_MULT_SIGNED_EN
        if (av[w-1]) sa = sa - (longint'(1) << w);
        if (bv[w-1]) sb = sb - (longint'(1) << w);
`endif
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Driver tasks (all at posedge+1)
    task automatic send4(input logic [3:0] av, input logic [3:0] bv);
        int n;
        n = 0;
        a4 = av;
        b4 = bv;
        in_valid4 = 1'b1;
        while (!in_ready4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check("send4_ready_timeout", 0, 1);
        @(posedge clk); #1;
        if (!hold_valid) in_valid4 = 1'b0;
        accept_cyc = cyc;
        exp_q.push_back(model(4, 32'(av), 32'(bv)));
        check("accept_in_ready", 64'(in_ready4), 0);
        check("accept_busy", 64'(busy4), 1);
        check("accept_state", 64'(dbg4), 1);
    endtask

    task automatic collect4(input int stall, input bit wiggle);
        int n, busy_n;
        logic [7:0] held;
        n = 0;
        busy_n = 0;
        out_ready4 = (stall == 0);
        while (!out_valid4 && n < 40) begin
            busy_n += int'(busy4);
            if (wiggle) begin
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                in_valid4 = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            n++;
        end
        if (wiggle) in_valid4 = 1'b0;
        if (n >= 40) begin
            check("collect4_timeout", 0, 1);
            out_ready4 = 1'b1;
            return;
        end
        check("latency", 64'(n), 4);
        check("busy_cycles", 64'(busy_n), 4);
        check("done_in_ready", 64'(in_ready4), 0);
        check("done_busy", 64'(busy4), 0);
        check("prod", 64'(prod4), exp_q.pop_front());
        held = prod4;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(out_valid4), 1);
            check("stall_prod", 64'(prod4), 64'(held));
            check("stall_in_ready", 64'(in_ready4), 0);
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        check("post_out_valid", 64'(out_valid4), 0);
        check("post_in_ready", 64'(in_ready4), 1);
        check("post_prod_kept", 64'(prod4), 64'(held));
    endtask

    task automatic txn8(input logic [7:0] av, input logic [7:0] bv);
        int n;
        n = 0;
        a8 = av;
        b8 = bv;
        in_valid8 = 1'b1;
        while (!in_ready8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8_latency", 64'(n), 8);
        check("w8_prod", 64'(prod8), model(8, 32'(av), 32'(bv)));
        @(posedge clk); #1;
        check("w8_post_valid", 64'(out_valid8), 0);
    endtask

    // Directed operand table with literal expected products for each build.
    logic [3:0] dir_a[3] = '{4'd13, 4'd7, 4'd8};
    logic [3:0] dir_b[3] = '{4'd9, 4'd8, 4'd8};
`ifdef SEQ_ARRAY_MULT_SIGNED_EN
    logic [7:0] dir_p[3] = '{8'h15, 8'hC8, 8'h40};
`else
    logic [7:0] dir_p[3] = '{8'h75, 8'h38, 8'h40};
`endif

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready4), 1);
        check("rst_out_valid", 64'(out_valid4), 0);
        check("rst_busy", 64'(busy4), 0);
        check("rst_prod", 64'(prod4), 0);
        check("rst_state", 64'(dbg4), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table, including the 13*9 latency/busy case.
        for (int i = 0; i < 3; i++) begin
            send4(dir_a[i], dir_b[i]);
            collect4(0, 1'b0);
            check("dir_prod_lit", 64'(prod4), 64'(dir_p[i]));
        end

        // Back-to-back with in_valid held: acceptances 6 cycles apart, zero operand still 4 cycles.
        hold_valid = 1'b1;
        send4(4'd15, 4'd15);
        c0 = accept_cyc;
        collect4(0, 1'b0);
        send4(4'd0, 4'd7);
        check("b2b_spacing_1", 64'(accept_cyc - c0), 6);
        c0 = accept_cyc;
        collect4(0, 1'b0);
        hold_valid = 1'b0;
        send4(4'd8, 4'd15);
        check("b2b_spacing_2", 64'(accept_cyc - c0), 6);
        collect4(0, 1'b0);

        // Backpressure: result held for 5 stalled cycles.
        send4(4'd10, 4'd10);
        collect4(5, 1'b0);

        // Reset mid-CALC aborts the transaction immediately.
        send4(4'd7, 4'd3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("abort_in_ready", 64'(in_ready4), 1);
        check("abort_out_valid", 64'(out_valid4), 0);
        check("abort_busy", 64'(busy4), 0);
        check("abort_prod", 64'(prod4), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send4(4'd12, 4'd3);
        collect4(0, 1'b0);

        // Randomized traffic with stalls and input noise while busy.
        for (int i = 0; i < 40; i++) begin
            send4(4'($urandom), 4'($urandom));
            collect4($urandom_range(0, 3), 1'b1);
        end

        // WIDTH=8 corners and random pairs.
        txn8(8'd255, 8'd255);
        txn8(8'd128, 8'd2);
        txn8(8'd0, 8'd255);
        for (int i = 0; i < 10; i++) txn8(8'($urandom), 8'($urandom));

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
